synch_count_ctrl: RTL and testbench

//  Sequencer for the Nbits synchronous up-counter datapath. Generates the

---
 rtl/synch_count_ctrl_pkg.sv | 15 +
 rtl/synch_count_ctrl_tick_prescaler.sv | 39 +++
 rtl/synch_count_ctrl.sv | 123 ++++++++++++
 tb/tb_synch_count_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synch_count_ctrl_pkg.sv
// Shared types for the synch_count_ctrl sequencer: FSM state encoding and
// run-mode values.
package synch_count_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic ModeOneshot  = 1'b0;
    localparam logic ModePeriodic = 1'b1;

endpackage

// File: rtl/synch_count_ctrl_tick_prescaler.sv
// Prescaler for the count-enable strobe: fires once every (div+1) cycles
// in which run is high, holding its phase while run is low.
module synch_count_ctrl_tick_prescaler #(
    parameter int unsigned PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                clr,
    input  logic [PRE_BITS-1:0] div,
    output logic                tick
);

    localparam logic [PRE_BITS-1:0] One = PRE_BITS'(1);

    logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;

    assign tick = run && (pre_cnt_q == div);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
        end else if (run) begin
            pre_cnt_d = pre_cnt_q + One;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/synch_count_ctrl.sv
// Sequencer for the Nbits up-counter: prescaled strobe, terminal-count
// detection, one-shot / auto-reload runs with start/pause/resume/abort.
module synch_count_ctrl
    import synch_count_ctrl_pkg::*;
#(
    parameter int unsigned Nbits    = 4,
    parameter int unsigned PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic [PRE_BITS-1:0] prescale,
    input  logic [Nbits-1:0]    term,
    output logic [Nbits-1:0]    counter,
    output logic                ena,
    output logic                busy,
    output logic                done,
    output logic                wrap
);

    localparam logic [Nbits-1:0] One = Nbits'(1);

    state_e              state_q, state_d;
    logic [Nbits-1:0]    counter_q, counter_d;
    logic [Nbits-1:0]    term_q, term_d;
    logic [PRE_BITS-1:0] pre_q, pre_d;
    logic                mode_q, mode_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;
    logic                launch, run, clr, tick;

    // Simultaneous start & stop from IDLE/DONE is ignored; stop wins elsewhere.
    assign launch = ((state_q == StIdle) || (state_q == StDone)) && start && !stop;
    assign run    = (state_q == StRun) && !stop;
    assign clr    = launch || ((state_q == StPause) && stop);

    synch_count_ctrl_tick_prescaler #(
        .PRE_BITS(PRE_BITS)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run),
        .clr (clr),
        .div (pre_q),
        .tick(tick)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        term_d    = term_q;
        pre_d     = pre_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (launch) begin
                    mode_d    = mode;
                    pre_d     = prescale;
                    term_d    = term;
                    counter_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else if (tick) begin
                    if (counter_q == term_q) begin
                        wrap_d = 1'b1;
                        if (mode_q == ModeOneshot) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            counter_d = '0;
                        end
                    end else begin
                        counter_d = counter_q + One;
                    end
                end
            end
            StPause: begin
                if (stop) begin
                    counter_d = '0;
                    state_d   = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            counter_q <= '0;
            term_q    <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            term_q    <= term_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign counter = counter_q;
    assign ena     = tick;
    assign busy    = (state_q == StRun) || (state_q == StPause);
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_synch_count_ctrl.sv
// Self-checking bench for synch_count_ctrl: directed scenarios plus random
// start/stop traffic against a strobe-counting reference model.
module tb_synch_count_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic [3:0] term = 4'd0;
    logic [3:0] counter;
    logic       ena, busy, done, wrap;

    int passed = 0;
    int total  = 0;

    // Model: a run is a number of active (unpaused) cycles and a number of strobes.
    bit m_busy, m_paused, m_done, m_wrap;
    int m_mode, m_div, m_term, m_active, m_strobes;

    synch_count_ctrl #(
        .Nbits   (4),
        .PRE_BITS(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .prescale(prescale),
        .term    (term),
        .counter (counter),
        .ena     (ena),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] exp_counter();
        if (m_mode == 0 && m_strobes > m_term) return m_term[3:0];
        return 4'(m_strobes % (m_term + 1));
    endfunction

    function automatic logic exp_ena();
        return m_busy && !m_paused && ((m_active % (m_div + 1)) == m_div);
    endfunction

    function automatic logic [7:0] exp_vec();
        return {exp_counter(), m_busy, exp_ena(), m_done, m_wrap};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_paused = 0; m_done = 0; m_wrap = 0;
        m_mode = 0; m_div = 0; m_term = 0; m_active = 0; m_strobes = 0;
    endtask

    // Apply one cycle of start/stop, advance the clock and the model together.
    task automatic cycle(input bit s, input bit p);
        bit strobe;
        start = s;
        stop  = p;
        @(posedge clk);
        strobe = exp_ena() && !p;
        m_done = 0;
        m_wrap = 0;
        if (!m_busy) begin
            if (s && !p) begin
                m_mode = int'(mode); m_div = int'(prescale); m_term = int'(term);
                m_busy = 1; m_paused = 0; m_active = 0; m_strobes = 0;
            end
        end else if (!m_paused) begin
            if (p) begin
                m_paused = 1;
            end else begin
                if (strobe) begin
                    m_strobes++;
                    if (m_strobes % (m_term + 1) == 0) begin
                        m_wrap = 1;
                        if (m_mode == 0) begin
                            m_done = 1;
                            m_busy = 0;
                        end
                    end
                end
                m_active++;
            end
        end else begin
            if (p) begin
                m_busy = 0; m_paused = 0; m_strobes = 0; m_active = 0;
            end else if (s) begin
                m_paused = 0;
            end
        end
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        #50;
        if ({counter, busy, ena, done, wrap} !== 8'h00) begin
            $display("FAIL reset_hold: got %b expected %b", {counter, busy, ena, done, wrap}, 8'h00);
        end else passed++;
        total++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL reset_idle[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
    endtask

    task automatic test_oneshot();
        int dones = 0;
        int wraps = 0;
        mode = 1'b0; prescale = 8'd0; term = 4'd5;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            dones += int'(done);
            wraps += int'(wrap);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL oneshot_seq[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
        if (dones != 1 || wraps != 1) begin
            $display("FAIL oneshot_pulses: got done=%0d wrap=%0d expected 1 1", dones, wraps);
        end else passed++;
        total++;
        if (counter !== 4'd5 || busy !== 1'b0) begin
            $display("FAIL oneshot_final: got counter=%0d busy=%b expected 5 0", counter, busy);
        end else passed++;
        total++;
    endtask

    task automatic test_periodic();
        int enas = 0;
        int wraps = 0;
        int idle_seen = 0;
        mode = 1'b1; prescale = 8'd3; term = 4'd15;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 70; i++) begin
            cycle(1'b0, 1'b0);
            enas += int'(ena);
            wraps += int'(wrap);
            idle_seen += int'(!busy);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL periodic_seq[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
        if (enas != 17 || wraps != 1 || idle_seen != 0) begin
            $display("FAIL periodic_counts: got ena=%0d wrap=%0d idle=%0d expected 17 1 0",
                     enas, wraps, idle_seen);
        end else passed++;
        total++;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
            $display("FAIL periodic_abort: got %b expected %b",
                     {counter, busy, ena, done, wrap}, exp_vec());
        end else passed++;
        total++;
    endtask

    task automatic test_pause();
        int n = 0;
        mode = 1'b0; prescale = 8'd1; term = 4'd10;
        cycle(1'b1, 1'b0);
        while (exp_counter() != 4'd3 && n < 50) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        if (counter !== 4'd3 || n >= 50) begin
            $display("FAIL pause_reach3: got counter=%0d after %0d cycles expected 3", counter, n);
        end else passed++;
        total++;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0);
            if (counter !== 4'd3 || busy !== 1'b1 || ena !== 1'b0) begin
                $display("FAIL pause_hold[%0d]: got counter=%0d busy=%b ena=%b expected 3 1 0",
                         i, counter, busy, ena);
            end else passed++;
            total++;
        end
        cycle(1'b1, 1'b0);
        n = 0;
        while (exp_counter() != 4'd4 && n < 10) begin
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL pause_resume[%0d]: got %b expected %b", n,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
            cycle(1'b0, 1'b0);
            n++;
        end
        if (counter !== 4'd4 || n >= 10) begin
            $display("FAIL pause_reach4: got counter=%0d expected 4", counter);
        end else passed++;
        total++;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        if (counter !== 4'd0 || busy !== 1'b0) begin
            $display("FAIL pause_abort: got counter=%0d busy=%b expected 0 0", counter, busy);
        end else passed++;
        total++;
    endtask

    task automatic test_corner();
        int wraps = 0;
        mode = 1'b1; prescale = 8'd0; term = 4'd3;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        if (busy !== 1'b0 || counter !== exp_counter()) begin
            $display("FAIL corner_startstop: got busy=%b counter=%0d expected 0 %0d",
                     busy, counter, exp_counter());
        end else passed++;
        total++;
        term = 4'd0;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            wraps += int'(wrap);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL corner_term0[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
        if (wraps != 8) begin
            $display("FAIL corner_term0_wraps: got %0d expected 8", wraps);
        end else passed++;
        total++;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        int n = 0;
        mode = 1'b1; prescale = 8'd0; term = 4'd15;
        cycle(1'b1, 1'b0);
        while (exp_counter() != 4'd7 && n < 40) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        if (counter !== 4'd7 || busy !== 1'b1) begin
            $display("FAIL async_pre: got counter=%0d busy=%b expected 7 1", counter, busy);
        end else passed++;
        total++;
        #4;
        rst = 1'b0;
        #1;
        if ({counter, busy, ena, done, wrap} !== 8'h00) begin
            $display("FAIL async_clear: got %b expected %b", {counter, busy, ena, done, wrap}, 8'h00);
        end else passed++;
        total++;
        model_reset();
        #4;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL async_after[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mode     = 1'($urandom_range(0, 1));
            prescale = 8'($urandom_range(0, 3));
            term     = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
            if ({counter, busy, ena, done, wrap} !== exp_vec()) begin
                $display("FAIL random[%0d]: got %b expected %b", i,
                         {counter, busy, ena, done, wrap}, exp_vec());
            end else passed++;
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_corner();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
